// File: rtl/sequence_generator.sv
// Sequence generator: drives a programmed sequence of symbols onto a
// valid/ready symbol bus. It can repeat the sequence, insert idle gaps after
// every accepted symbol, and be aborted at any time.
module sequence_generator #(
  parameter int                          DATA_W     = 3,
  parameter int                          SEQ_LEN    = 3,
  parameter logic [SEQ_LEN*DATA_W-1:0]   SEQ        = {3'b100, 3'b010, 3'b001},
  parameter logic [DATA_W-1:0]           IDLE_SYM   = 3'b000,
  parameter int                          GAP_CYCLES = 0,
  parameter int                          CNT_W      = 8,
  localparam int                         IDX_W      = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  repeat_cnt,
  input  logic              abort,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  sym_idx
);

  localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int               GAP_LASTI = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LASTI);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SEQ_LEN - 1);
  localparam bit               HAS_GAP  = (GAP_CYCLES > 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [CNT_W-1:0]   rep_reg, rep_next;
  logic [GAP_W-1:0]   gap_reg, gap_next;
  logic               done_reg, done_next;
  logic               advance;

  // Unpack the sequence parameter into an indexable symbol table.
  logic [DATA_W-1:0]  seq_rom [SEQ_LEN];

  genvar gi;
  generate
    for (gi = 0; gi < SEQ_LEN; gi++) begin : g_rom
      assign seq_rom[gi] = SEQ[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // State register; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      idx_reg   <= '0;
      rep_reg   <= '0;
      gap_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      rep_reg   <= rep_next;
      gap_reg   <= gap_next;
      done_reg  <= done_next;
    end
  end

  // Next-state logic: start/abort handling, handshake, gap timing, advance.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    rep_next   = rep_reg;
    gap_next   = gap_reg;
    done_next  = 1'b0;
    advance    = 1'b0;

    case (state_reg)
      S_IDLE: begin
        // The done cycle itself does not accept a new start.
        if (start && !abort && !done_reg) begin
          state_next = S_SEND;
          idx_next   = '0;
          rep_next   = (repeat_cnt == '0) ? CNT_W'(1) : repeat_cnt;
        end
      end
      S_SEND: begin
        if (abort) begin
          state_next = S_IDLE;
          idx_next   = '0;
        end else if (data_ready) begin
          if (HAS_GAP) begin
            state_next = S_GAP;
            gap_next   = '0;
          end else begin
            advance = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          state_next = S_IDLE;
          idx_next   = '0;
        end else if (gap_reg == GAP_LAST) begin
          advance = 1'b1;
        end else begin
          gap_next = gap_reg + 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
        idx_next   = '0;
      end
    endcase

    // Move to the next symbol, the next repetition, or finish.
    if (advance) begin
      if (idx_reg != IDX_LAST) begin
        idx_next   = idx_reg + 1'b1;
        state_next = S_SEND;
      end else if (rep_reg > CNT_W'(1)) begin
        idx_next   = '0;
        rep_next   = rep_reg - 1'b1;
        state_next = S_SEND;
      end else begin
        idx_next   = '0;
        rep_next   = '0;
        state_next = S_IDLE;
        done_next  = 1'b1;
      end
    end
  end

  // Output decode from the registered state.
  always_comb begin
    data_valid = (state_reg == S_SEND);
    data       = data_valid ? seq_rom[idx_reg] : IDLE_SYM;
    busy       = (state_reg != S_IDLE);
    done       = done_reg;
    sym_idx    = idx_reg;
  end

endmodule

// File: tb/tb_sequence_generator.sv
// Bench for sequence_generator: one instance without gaps (a_*) and one with
// two gap cycles (b_*) share stimulus; directed scenarios plus a randomized
// run checked against a transfer-counting reference model.
module tb_sequence_generator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       ready = 1'b1;
  logic [7:0] repeat_cnt = 8'd1;

  logic [2:0] a_data, b_data;
  logic       a_valid, b_valid, a_busy, b_busy, a_done, b_done;
  logic [1:0] a_idx, b_idx;

  int checks = 0;
  int failures = 0;
  int xfer_a = 0;
  int xfer_b = 0;

  logic [2:0] syms [3] = '{3'b001, 3'b010, 3'b100};

  // Reference model: per instance, active flag, transfers done, total
  // transfers for the run, gap cycles left, and the done pulse.
  bit m_act  [2];
  int m_k    [2];
  int m_total[2];
  int m_gap  [2];
  bit m_done [2];
  int gaps   [2] = '{0, 2};

  always #5 clk = ~clk;

  sequence_generator #(.GAP_CYCLES(0)) dut_a (
    .clk(clk), .reset(reset), .start(start), .repeat_cnt(repeat_cnt), .abort(abort),
    .data(a_data), .data_valid(a_valid), .data_ready(ready), .busy(a_busy),
    .done(a_done), .sym_idx(a_idx)
  );

  sequence_generator #(.GAP_CYCLES(2)) dut_b (
    .clk(clk), .reset(reset), .start(start), .repeat_cnt(repeat_cnt), .abort(abort),
    .data(b_data), .data_valid(b_valid), .data_ready(ready), .busy(b_busy),
    .done(b_done), .sym_idx(b_idx)
  );

  task automatic model_step(input int i);
    bit ev;
    bit nd;
    ev = m_act[i] && (m_gap[i] == 0);
    if (reset) begin
      m_act[i] = 0; m_k[i] = 0; m_gap[i] = 0; m_done[i] = 0;
    end else begin
      nd = 0;
      if (!m_act[i]) begin
        if (start && !abort && !m_done[i]) begin
          m_act[i]   = 1;
          m_k[i]     = 0;
          m_gap[i]   = 0;
          m_total[i] = 3 * ((repeat_cnt == 0) ? 1 : int'(repeat_cnt));
        end
      end else if (abort) begin
        m_act[i] = 0;
      end else if (m_gap[i] > 0) begin
        m_gap[i]--;
        if (m_gap[i] == 0 && m_k[i] == m_total[i]) begin
          m_act[i] = 0; nd = 1;
        end
      end else if (ev && ready) begin
        m_k[i]++;
        if (gaps[i] > 0) m_gap[i] = gaps[i];
        else if (m_k[i] == m_total[i]) begin
          m_act[i] = 0; nd = 1;
        end
      end
      m_done[i] = nd;
    end
  endtask

  // Advance one clock: update the model from the inputs seen at the edge,
  // count bus transfers, then settle past the edge.
  task automatic tick();
    if (!reset && a_valid && ready) xfer_a++;
    if (!reset && b_valid && ready) xfer_b++;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until both instances are idle and past any done pulse.
  task automatic settle();
    int n;
    n = 0;
    while ((a_busy || b_busy || a_done || b_done) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (a_busy || b_busy || a_done || b_done) begin
      failures++;
      $display("FAIL settle_timeout: busy=%b/%b done=%b/%b required idle", a_busy, b_busy, a_done, b_done);
    end
  endtask

  task automatic test_reset();
    reset = 1; start = 1; ready = 1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if ({a_data, a_valid, a_busy, a_done} !== 6'b000_000) begin
        failures++;
        $display("FAIL reset_a: data=%b valid=%b busy=%b done=%b required 000/0/0/0", a_data, a_valid, a_busy, a_done);
      end
      checks++;
      if ({b_data, b_valid, b_busy, b_done, b_idx} !== 8'b000_000_00) begin
        failures++;
        $display("FAIL reset_b: data=%b valid=%b busy=%b done=%b idx=%0d required zeros", b_data, b_valid, b_busy, b_done, b_idx);
      end
    end
    reset = 0; start = 0;
    tick();
    checks++;
    if (a_busy !== 1'b0 || a_idx !== 2'd0) begin
      failures++;
      $display("FAIL reset_release: busy=%b idx=%0d required 0/0", a_busy, a_idx);
    end
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_basic();
    settle();
    ready = 1; repeat_cnt = 1; start = 1;
    tick();
    start = 0;
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (a_valid !== 1'b1 || a_data !== syms[j] || a_idx !== 2'(j)) begin
        failures++;
        $display("FAIL basic_sym%0d: valid=%b data=%b idx=%0d required 1/%b/%0d", j, a_valid, a_data, a_idx, syms[j], j);
      end
      tick();
    end
    checks++;
    if (a_done !== 1'b1 || a_busy !== 1'b0 || a_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_done: done=%b busy=%b valid=%b required 1/0/0", a_done, a_busy, a_valid);
    end
    tick();
    checks++;
    if (a_done !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_width: done=%b required 0", a_done);
    end
    $display("test_basic done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_backpressure();
    settle();
    xfer_a = 0;
    ready = 1; repeat_cnt = 1; start = 1;
    tick();
    start = 0;
    tick();
    ready = 0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (a_valid !== 1'b1 || a_data !== 3'b010 || a_idx !== 2'd1) begin
        failures++;
        $display("FAIL bp_hold%0d: valid=%b data=%b idx=%0d required 1/010/1", c, a_valid, a_data, a_idx);
      end
      if (c < 4) tick();
    end
    ready = 1;
    tick();
    checks++;
    if (a_valid !== 1'b1 || a_data !== 3'b100 || a_idx !== 2'd2) begin
      failures++;
      $display("FAIL bp_resume: valid=%b data=%b idx=%0d required 1/100/2", a_valid, a_data, a_idx);
    end
    tick();
    checks++;
    if (a_done !== 1'b1 || xfer_a != 3) begin
      failures++;
      $display("FAIL bp_total: done=%b transfers=%0d required 1/3", a_done, xfer_a);
    end
    $display("test_backpressure done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_repeat_gap();
    bit       ev;
    logic [2:0] ed;
    int       done_cnt;
    settle();
    xfer_b = 0; done_cnt = 0;
    ready = 1; repeat_cnt = 2; start = 1;
    tick();
    start = 0;
    for (int t = 0; t < 21; t++) begin
      ev = (t % 3 == 0) && (t < 18);
      ed = ev ? syms[(t / 3) % 3] : 3'b000;
      if (b_done === 1'b1) done_cnt++;
      checks++;
      if (b_valid !== ev || b_data !== ed || b_done !== (t == 18) || b_busy !== (t < 18)) begin
        failures++;
        $display("FAIL gap_t%0d: valid=%b data=%b done=%b busy=%b required %b/%b/%b/%b", t, b_valid, b_data, b_done, b_busy, ev, ed, (t == 18), (t < 18));
      end
      checks++;
      if (a_valid !== (t < 6) || a_done !== (t == 6)) begin
        failures++;
        $display("FAIL rep_nogap_t%0d: valid=%b done=%b required %b/%b", t, a_valid, a_done, (t < 6), (t == 6));
      end
      tick();
    end
    checks++;
    if (xfer_b != 6 || done_cnt != 1) begin
      failures++;
      $display("FAIL gap_totals: transfers=%0d done_pulses=%0d required 6/1", xfer_b, done_cnt);
    end
    $display("test_repeat_gap done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_abort();
    settle();
    ready = 1; repeat_cnt = 1; start = 1;
    tick();
    start = 0;
    tick();
    checks++;
    if (a_data !== 3'b010 || b_busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre: data=%b b_busy=%b required 010/1", a_data, b_busy);
    end
    abort = 1;
    tick();
    abort = 0;
    checks++;
    if (a_valid !== 1'b0 || a_busy !== 1'b0 || a_data !== 3'b000 || a_done !== 1'b0 || b_busy !== 1'b0 || b_done !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle: valid=%b busy=%b data=%b done=%b b_busy=%b b_done=%b required 0/0/000/0/0/0", a_valid, a_busy, a_data, a_done, b_busy, b_done);
    end
    tick();
    checks++;
    if (a_done !== 1'b0 || b_done !== 1'b0) begin
      failures++;
      $display("FAIL abort_nodone: done=%b/%b required 0/0", a_done, b_done);
    end
    start = 1;
    tick();
    start = 0;
    checks++;
    if (a_valid !== 1'b1 || a_data !== 3'b001 || a_idx !== 2'd0) begin
      failures++;
      $display("FAIL abort_restart: valid=%b data=%b idx=%0d required 1/001/0", a_valid, a_data, a_idx);
    end
    $display("test_abort done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_corners();
    int n;
    // repeat_cnt of zero runs the sequence once
    settle();
    xfer_a = 0; ready = 1; repeat_cnt = 0; start = 1;
    tick();
    start = 0;
    n = 0;
    while (a_done !== 1'b1 && n < 50) begin tick(); n++; end
    checks++;
    if (a_done !== 1'b1 || xfer_a != 3) begin
      failures++;
      $display("FAIL rep_zero: done=%b transfers=%0d required 1/3", a_done, xfer_a);
    end
    // start while busy is ignored and does not re-latch the count
    settle();
    xfer_a = 0; repeat_cnt = 1; start = 1;
    tick();
    start = 0;
    tick();
    repeat_cnt = 5; start = 1;
    tick();
    start = 0;
    n = 0;
    while (a_done !== 1'b1 && n < 50) begin tick(); n++; end
    checks++;
    if (a_done !== 1'b1 || xfer_a != 3) begin
      failures++;
      $display("FAIL start_busy: done=%b transfers=%0d required 1/3", a_done, xfer_a);
    end
    // start and abort together in IDLE: abort wins
    settle();
    start = 1; abort = 1;
    tick();
    start = 0; abort = 0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (a_busy !== 1'b0 || a_valid !== 1'b0 || b_busy !== 1'b0) begin
        failures++;
        $display("FAIL start_abort%0d: busy=%b valid=%b b_busy=%b required 0/0/0", c, a_busy, a_valid, b_busy);
      end
      tick();
    end
    // start during the done cycle is not accepted
    settle();
    repeat_cnt = 1; start = 1;
    tick();
    start = 0;
    n = 0;
    while (a_done !== 1'b1 && n < 50) begin tick(); n++; end
    start = 1;
    tick();
    start = 0;
    checks++;
    if (a_busy !== 1'b0 || a_valid !== 1'b0) begin
      failures++;
      $display("FAIL start_in_done: busy=%b valid=%b required 0/0", a_busy, a_valid);
    end
    $display("test_corners done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_random();
    bit         ev, ob, odn, ov;
    logic [2:0] ed, od;
    logic [1:0] oi;
    reset = 1;
    tick();
    reset = 0;
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 299) == 0);
      start      = ($urandom_range(0, 5) == 0);
      abort      = ($urandom_range(0, 39) == 0);
      ready      = ($urandom_range(0, 9) < 7);
      repeat_cnt = 8'($urandom_range(0, 3));
      tick();
      for (int i = 0; i < 2; i++) begin
        od  = (i == 0) ? a_data  : b_data;
        ov  = (i == 0) ? a_valid : b_valid;
        ob  = (i == 0) ? a_busy  : b_busy;
        odn = (i == 0) ? a_done  : b_done;
        oi  = (i == 0) ? a_idx   : b_idx;
        ev  = m_act[i] && (m_gap[i] == 0);
        ed  = ev ? syms[m_k[i] % 3] : 3'b000;
        checks++;
        if (ov !== ev || od !== ed || ob !== m_act[i] || odn !== m_done[i] || (ev && oi !== 2'(m_k[i] % 3))) begin
          failures++;
          $display("FAIL rand_c%0d_dut%0d: valid=%b data=%b busy=%b done=%b idx=%0d required %b/%b/%b/%b/%0d",
                   c, i, ov, od, ob, odn, oi, ev, ed, m_act[i], m_done[i], m_k[i] % 3);
        end
      end
    end
    reset = 0; start = 0; abort = 0; ready = 1;
    $display("test_random done checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_repeat_gap();
    test_abort();
    test_corners();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
